// File: rtl/datapath_pkg.sv
// Shared datapath types plus the writeback arbiter's source enum and buffered entry format.
package datapath_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic {
      WB_SRC_ALU  = 1'b0,
      WB_SRC_LOAD = 1'b1
   } wb_src_t;

   typedef struct packed {
      word_t    wdat;
      regbits_t reg_sel;
      logic     spec;
   } wb_entry_t;

   function automatic wb_src_t wb_other_src(input wb_src_t src);
      return (src == WB_SRC_ALU) ? WB_SRC_LOAD : WB_SRC_ALU;
   endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// In-order skid FIFO for one writeback source, with per-entry speculation bits that
// can be cleared (branch resolved correct) or squashed (branch mispredicted).
module wb_skid_fifo
   import datapath_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      i_push,
   input  wb_entry_t i_din,
   output logic      o_ready,
   input  logic      i_pop,
   output wb_entry_t o_head,
   output logic      o_empty,
   input  logic      i_clear_spec,
   input  logic      i_squash_spec
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   word_t            r_wdat [DEPTH];
   regbits_t         r_sel  [DEPTH];
   logic [DEPTH-1:0] r_spec;
   logic [PW-1:0]    r_head;
   logic [CW-1:0]    r_count;

   logic          w_accept;
   logic          w_store;
   logic [CW-1:0] w_spec_cnt;
   logic [CW-1:0] w_keep;
   logic [PW-1:0] w_wr_ptr;
   logic [CW-1:0] w_count_nxt;

   assign o_ready  = (r_count != FULL);
   assign o_empty  = (r_count == '0);
   assign o_head   = '{wdat: r_wdat[r_head], reg_sel: r_sel[r_head], spec: r_spec[r_head]};

   // A speculative push that lands on a squash is accepted but never stored.
   assign w_accept = i_push && o_ready;
   assign w_store  = w_accept && !(i_squash_spec && i_din.spec);

   always_comb begin
      w_spec_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_count) && r_spec[r_head + PW'(i)]) begin
            w_spec_cnt = w_spec_cnt + CW'(1);
         end
      end
   end

   // Speculative entries are always the youngest, so a squash just rewinds the tail.
   assign w_keep      = i_squash_spec ? (r_count - w_spec_cnt) : r_count;
   assign w_wr_ptr    = r_head + w_keep[PW-1:0];
   assign w_count_nxt = w_keep - CW'(i_pop) + CW'(w_store);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_head  <= '0;
         r_count <= '0;
         r_spec  <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (i_pop) begin
            r_head <= r_head + PW'(1);
         end
         if (i_clear_spec || i_squash_spec) begin
            r_spec <= '0;
         end
         if (w_store) begin
            r_spec[w_wr_ptr] <= i_din.spec && !i_clear_spec;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_store) begin
         r_wdat[w_wr_ptr] <= i_din.wdat;
         r_sel[w_wr_ptr]  <= i_din.reg_sel;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load unit.
// Optional WB_ARB_PERF_EN adds a saturating conflict_cnt of cycles with both heads eligible.
module writeback_arbiter
   import datapath_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 32,
   parameter int RW    = 5
)
(
   input  logic          CLK,
   input  logic          nRST,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [DW-1:0] alu_wdat,
   input  logic [RW-1:0] alu_reg_sel,
   input  logic          alu_spec,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [DW-1:0] load_wdat,
   input  logic [RW-1:0] load_reg_sel,
   input  logic          branch_mispredict,
   input  logic          branch_correct,
   output logic          wb_wen,
   output logic [RW-1:0] wb_sel,
   output logic [DW-1:0] wb_wdat
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]   conflict_cnt
`endif
);

   wb_entry_t w_alu_din;
   wb_entry_t w_load_din;
   wb_entry_t w_alu_head;
   wb_entry_t w_load_head;
   logic      w_alu_empty;
   logic      w_load_empty;
   logic      w_alu_pop;
   logic      w_load_pop;
   logic      w_alu_elig;
   logic      w_load_elig;
   logic      w_both;
   logic      w_clear_spec;
   logic      w_grant;
   wb_src_t   w_grant_src;
   wb_src_t   w_last_nxt;
   regbits_t  w_grant_sel;
   word_t     w_grant_wdat;

   wb_src_t       r_last_grant;
   logic          r_wb_wen;
   logic [RW-1:0] r_wb_sel;
   logic [DW-1:0] r_wb_wdat;

   assign w_alu_din  = '{wdat: word_t'(alu_wdat), reg_sel: regbits_t'(alu_reg_sel), spec: alu_spec};
   assign w_load_din = '{wdat: word_t'(load_wdat), reg_sel: regbits_t'(load_reg_sel), spec: 1'b0};

   // Mispredict takes priority when both resolutions arrive together.
   assign w_clear_spec = branch_correct && !branch_mispredict;

   wb_skid_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .CLK           (CLK),
      .nRST          (nRST),
      .i_push        (alu_valid),
      .i_din         (w_alu_din),
      .o_ready       (alu_ready),
      .i_pop         (w_alu_pop),
      .o_head        (w_alu_head),
      .o_empty       (w_alu_empty),
      .i_clear_spec  (w_clear_spec),
      .i_squash_spec (branch_mispredict)
   );

   wb_skid_fifo #(.DEPTH(DEPTH)) u_load_fifo (
      .CLK           (CLK),
      .nRST          (nRST),
      .i_push        (load_valid),
      .i_din         (w_load_din),
      .o_ready       (load_ready),
      .i_pop         (w_load_pop),
      .o_head        (w_load_head),
      .o_empty       (w_load_empty),
      .i_clear_spec  (1'b0),
      .i_squash_spec (1'b0)
   );

   assign w_alu_elig  = !w_alu_empty && !w_alu_head.spec;
   assign w_load_elig = !w_load_empty && !w_load_head.spec;
   assign w_both      = w_alu_elig && w_load_elig;

   // last_grant only moves when there was a real contest between the two heads.
   always_comb begin
      w_grant     = 1'b0;
      w_grant_src = WB_SRC_ALU;
      w_last_nxt  = r_last_grant;
      if (w_both) begin
         w_grant     = 1'b1;
         w_grant_src = wb_other_src(r_last_grant);
         w_last_nxt  = w_grant_src;
      end else if (w_alu_elig) begin
         w_grant     = 1'b1;
         w_grant_src = WB_SRC_ALU;
      end else if (w_load_elig) begin
         w_grant     = 1'b1;
         w_grant_src = WB_SRC_LOAD;
      end
   end

   assign w_alu_pop    = w_grant && (w_grant_src == WB_SRC_ALU);
   assign w_load_pop   = w_grant && (w_grant_src == WB_SRC_LOAD);
   assign w_grant_sel  = (w_grant_src == WB_SRC_ALU) ? w_alu_head.reg_sel : w_load_head.reg_sel;
   assign w_grant_wdat = (w_grant_src == WB_SRC_ALU) ? w_alu_head.wdat : w_load_head.wdat;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_last_grant <= WB_SRC_LOAD;
         r_wb_wen     <= 1'b0;
         r_wb_sel     <= '0;
         r_wb_wdat    <= '0;
      end else begin
         r_last_grant <= w_last_nxt;
         r_wb_wen     <= w_grant && (w_grant_sel != '0);
         if (w_grant) begin
            r_wb_sel  <= RW'(w_grant_sel);
            r_wb_wdat <= DW'(w_grant_wdat);
         end
      end
   end

   assign wb_wen  = r_wb_wen;
   assign wb_sel  = r_wb_sel;
   assign wb_wdat = r_wb_wdat;

`ifdef WB_ARB_PERF_EN
   logic [31:0] r_conflict_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_conflict_cnt <= '0;
      end else if (w_both && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued at issue and a
// negedge monitor pops and compares them whenever wb_wen is seen.
module tb_writeback_arbiter;
   import datapath_pkg::*;

   localparam int DEPTH = 2;
   localparam int DW    = 32;
   localparam int RW    = 5;

   logic          CLK;
   logic          nRST;
   logic          alu_valid;
   logic          alu_ready;
   logic [DW-1:0] alu_wdat;
   logic [RW-1:0] alu_reg_sel;
   logic          alu_spec;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_wdat;
   logic [RW-1:0] load_reg_sel;
   logic          branch_mispredict;
   logic          branch_correct;
   logic          wb_wen;
   logic [RW-1:0] wb_sel;
   logic [DW-1:0] wb_wdat;
`ifdef WB_ARB_PERF_EN
   logic [31:0]   conflict_cnt;
`endif

   typedef struct packed {
      logic [RW-1:0] sel;
      logic [DW-1:0] wdat;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_writes = 0;
   logic spec_open = 1'b0;

   // Ready pattern after edge k (bit k) with both sources pushing from an empty reset state.
   logic [7:0] alu_rdy_tbl  = 8'b0101_0111;
   logic [7:0] load_rdy_tbl = 8'b1010_1011;

   writeback_arbiter #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) u_dut (
      .CLK               (CLK),
      .nRST              (nRST),
      .alu_valid         (alu_valid),
      .alu_ready         (alu_ready),
      .alu_wdat          (alu_wdat),
      .alu_reg_sel       (alu_reg_sel),
      .alu_spec          (alu_spec),
      .load_valid        (load_valid),
      .load_ready        (load_ready),
      .load_wdat         (load_wdat),
      .load_reg_sel      (load_reg_sel),
      .branch_mispredict (branch_mispredict),
      .branch_correct    (branch_correct),
      .wb_wen            (wb_wen),
      .wb_sel            (wb_sel),
      .wb_wdat           (wb_wdat)
`ifdef WB_ARB_PERF_EN
      ,
      .conflict_cnt      (conflict_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, expected test to finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [RW-1:0] sel, input logic [DW-1:0] wdat);
      exp_t e;
      e.sel  = sel;
      e.wdat = wdat;
      exp_q.push_back(e);
   endtask

   // Drives the ALU port; branch inputs must already be set for this cycle.
   task automatic alu_set(input logic v, input logic [RW-1:0] s, input logic [DW-1:0] d,
                          input logic sp);
      alu_valid   = v;
      alu_reg_sel = s;
      alu_wdat    = d;
      alu_spec    = sp;
      if (v && !sp && !branch_correct && !branch_mispredict)
         check("spec_order", {63'd0, spec_open}, 64'd0);
      if (v && sp) spec_open = 1'b1;
      if (branch_correct || branch_mispredict) spec_open = 1'b0;
   endtask

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic idle_all();
      load_valid   = 1'b0;
      load_reg_sel = '0;
      load_wdat    = '0;
      alu_set(1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      cyc();
      nRST              = 1'b0;
      branch_correct    = 1'b0;
      branch_mispredict = 1'b0;
      idle_all();
      spec_open = 1'b0;
      cyc();
      nRST = 1'b1;
   endtask

   task automatic pulse_correct();
      cyc();
      branch_correct = 1'b1;
      alu_set(1'b0, '0, '0, 1'b0);
      cyc();
      branch_correct = 1'b0;
      alu_set(1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         if (nRST === 1'b1 && wb_wen === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got sel=%0d data=0x%0h, expected no write",
                        wb_sel, wb_wdat);
            end else begin
               m_e = exp_q.pop_front();
               check("wb_sel", 64'(wb_sel), 64'(m_e.sel));
               check("wb_wdat", 64'(wb_wdat), 64'(m_e.wdat));
            end
         end
      end
   end

   initial begin
      int na;
      int nl;
      int w0;
      nRST              = 1'b0;
      branch_correct    = 1'b0;
      branch_mispredict = 1'b0;
      idle_all();
      repeat (2) cyc();
      check("rst_wen", 64'(wb_wen), 64'd0);
      check("rst_sel", 64'(wb_sel), 64'd0);
      check("rst_wdat", 64'(wb_wdat), 64'd0);
      check("rst_alu_ready", 64'(alu_ready), 64'd1);
      check("rst_load_ready", 64'(load_ready), 64'd1);
      nRST = 1'b1;

      // single ALU write, 2-cycle latency, one-cycle pulse
      cyc();
      alu_set(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
      expect_write(5'd5, 32'hDEAD_BEEF);
      cyc();
      alu_set(1'b0, '0, '0, 1'b0);
      check("t1_wen_edge_n", 64'(wb_wen), 64'd0);
      cyc();
      check("t1_wen_edge_n1", 64'(wb_wen), 64'd1);
      cyc();
      check("t1_wen_edge_n2", 64'(wb_wen), 64'd0);

      // both sources streaming: alternate ALU/LOAD starting with ALU, readys throttle
      do_reset();
      for (int i = 0; i < 6; i++) begin
         expect_write(5'd1, 32'hA0 + 32'(i));
         expect_write(5'd2, 32'hB0 + 32'(i));
      end
      na = 0;
      nl = 0;
      for (int k = 0; k < 30; k++) begin
         if (k > 0) cyc();
         if (k < 8) begin
            check($sformatf("t2_alu_ready_k%0d", k), 64'(alu_ready), 64'(alu_rdy_tbl[k]));
            check($sformatf("t2_load_ready_k%0d", k), 64'(load_ready), 64'(load_rdy_tbl[k]));
         end
         alu_set(na < 6, 5'd1, 32'hA0 + 32'(na), 1'b0);
         if (alu_valid && alu_ready) na++;
         load_valid   = (nl < 6);
         load_reg_sel = 5'd2;
         load_wdat    = 32'hB0 + 32'(nl);
         if (load_valid && load_ready) nl++;
      end
      idle_all();
      check("t2_alu_accepted", 64'(na), 64'd6);
      check("t2_load_accepted", 64'(nl), 64'd6);
      check("t2_all_written", 64'(exp_q.size()), 64'd0);

      // speculative entries held until branch_correct
      do_reset();
      alu_set(1'b1, 5'd3, 32'h33, 1'b1);
      cyc();
      alu_set(1'b1, 5'd4, 32'h44, 1'b1);
      cyc();
      alu_set(1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         check($sformatf("t3_hold_wen_%0d", k), 64'(wb_wen), 64'd0);
      end
      branch_correct = 1'b1;
      alu_set(1'b0, '0, '0, 1'b0);
      expect_write(5'd3, 32'h33);
      expect_write(5'd4, 32'h44);
      cyc();
      branch_correct = 1'b0;
      alu_set(1'b0, '0, '0, 1'b0);
      check("t3_wen_m1", 64'(wb_wen), 64'd0);
      cyc();
      check("t3_wen_m2", 64'(wb_wen), 64'd1);
      check("t3_sel_m2", 64'(wb_sel), 64'd3);
      cyc();
      check("t3_wen_m3", 64'(wb_wen), 64'd1);
      check("t3_sel_m3", 64'(wb_sel), 64'd4);
      cyc();
      check("t3_wen_m4", 64'(wb_wen), 64'd0);

      // mispredict squashes the speculative tail, non-spec entry still written
      do_reset();
      w0 = n_writes;
      alu_set(1'b1, 5'd6, 32'h66, 1'b0);
      expect_write(5'd6, 32'h66);
      cyc();
      alu_set(1'b1, 5'd7, 32'h77, 1'b1);
      cyc();
      alu_set(1'b1, 5'd8, 32'h88, 1'b1);
      cyc();
      check("t4_full_before_squash", 64'(alu_ready), 64'd0);
      branch_mispredict = 1'b1;
      alu_set(1'b0, '0, '0, 1'b0);
      cyc();
      branch_mispredict = 1'b0;
      alu_set(1'b0, '0, '0, 1'b0);
      check("t4_ready_after_squash", 64'(alu_ready), 64'd1);
      pulse_correct();
      repeat (4) cyc();
      check("t4_write_count", 64'(n_writes - w0), 64'd1);

      // spec push with correct is stored non-spec
      cyc();
      branch_correct = 1'b1;
      alu_set(1'b1, 5'd11, 32'hBB, 1'b1);
      expect_write(5'd11, 32'hBB);
      cyc();
      branch_correct = 1'b0;
      alu_set(1'b0, '0, '0, 1'b0);
      repeat (3) cyc();
      // spec push dropped on mispredict while the non-spec head is granted
      alu_set(1'b1, 5'd12, 32'hCC, 1'b0);
      expect_write(5'd12, 32'hCC);
      cyc();
      branch_mispredict = 1'b1;
      check("t5_drop_handshake_ready", 64'(alu_ready), 64'd1);
      alu_set(1'b1, 5'd13, 32'hDD, 1'b1);
      cyc();
      branch_mispredict = 1'b0;
      alu_set(1'b0, '0, '0, 1'b0);
      pulse_correct();
      repeat (3) cyc();
      // mispredict and correct together: mispredict wins
      alu_set(1'b1, 5'd14, 32'hEE, 1'b1);
      cyc();
      branch_mispredict = 1'b1;
      branch_correct    = 1'b1;
      alu_set(1'b0, '0, '0, 1'b0);
      cyc();
      branch_mispredict = 1'b0;
      branch_correct    = 1'b0;
      alu_set(1'b0, '0, '0, 1'b0);
      pulse_correct();
      repeat (4) cyc();
      check("t5_all_written", 64'(exp_q.size()), 64'd0);

      // r0 write is dequeued silently but still updates sel/wdat
      alu_set(1'b1, 5'd0, 32'h1234, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         alu_set(1'b0, '0, '0, 1'b0);
         check($sformatf("t6_r0_wen_%0d", k), 64'(wb_wen), 64'd0);
      end
      check("t6_r0_sel", 64'(wb_sel), 64'd0);
      check("t6_r0_wdat", 64'(wb_wdat), 64'h1234);

      // reset with two entries buffered discards them
      alu_set(1'b1, 5'd13, 32'h0D, 1'b1);
      cyc();
      alu_set(1'b1, 5'd14, 32'h0E, 1'b1);
      cyc();
      alu_set(1'b0, '0, '0, 1'b0);
      cyc();
      check("t7_buffered_full", 64'(alu_ready), 64'd0);
      nRST = 1'b0;
      #1;
      check("t7_rst_wen", 64'(wb_wen), 64'd0);
      check("t7_rst_wdat", 64'(wb_wdat), 64'd0);
      check("t7_rst_alu_ready", 64'(alu_ready), 64'd1);
      check("t7_rst_load_ready", 64'(load_ready), 64'd1);
      cyc();
      nRST      = 1'b1;
      spec_open = 1'b0;
      pulse_correct();
      repeat (4) cyc();
      check("t7_ready_after", 64'(alu_ready), 64'd1);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
